// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: FSM encoding and output buffer geometry.
// The output buffer depth is what bounds the number of outstanding reads.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned COUNT_W   = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry output buffer for the stream reader; push while full and pop while empty are ignored.
// The head entry drives data directly, so it stays stable until it is popped.
module stream_fifo2
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic [COUNT_W-1:0]    count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == COUNT_W'(BUF_DEPTH));
  assign empty   = (count == '0);
  assign data    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of consecutive words from a synchronous-read RAM and presents them as a
// valid/ready stream, keeping at most two words buffered or in flight.
//
// Stream handshake: a word transfers in a cycle where m_valid and m_ready are both high;
// once m_valid rises, it and m_data hold until that transfer happens.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done_tick
);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  in_flight_q;
  logic                  zero_done_q;
  logic [COUNT_W-1:0]    buf_count;
  logic                  buf_full;
  logic                  buf_empty;
  logic [COUNT_W-1:0]    occupancy;
  logic                  accept;
  logic                  pop;
  logic                  issue;
  logic                  last_issue;
  logic                  drain_done;

  assign accept    = (state == IDLE) && start;
  assign pop       = m_valid && m_ready;
  assign occupancy = buf_count + COUNT_W'(in_flight_q);

  // Issue while there is room for the returning word; a full slot count is fine only if a
  // word leaves this cycle (full buffer plus an in-flight word is the one case excluded).
  assign issue = (state == RUN) && (remaining_q != '0) &&
                 ((occupancy < COUNT_W'(BUF_DEPTH)) || (pop && !(buf_full && in_flight_q)));
  assign last_issue = issue && (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1});
  assign drain_done = (state == DRAIN) && !in_flight_q &&
                      (buf_empty || ((buf_count == COUNT_W'(1)) && pop));

  assign rd_addr   = addr_q;
  assign m_valid   = !buf_empty;
  assign busy      = (state != IDLE);
  assign done_tick = zero_done_q || drain_done;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && (len != '0)) state_next = RUN;
      RUN:     if (last_issue) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      in_flight_q <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state       <= state_next;
      in_flight_q <= issue;
      zero_done_q <= accept && (len == '0);
      // An empty burst leaves the address counter where it was.
      if (accept && (len != '0)) begin
        addr_q      <= base_addr;
        remaining_q <= len;
      end else if (issue) begin
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
    end
  end

  stream_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .push   (in_flight_q),
    .pop    (pop),
    .wr_data(rd_data),
    .data   (m_data),
    .count  (buf_count),
    .full   (buf_full),
    .empty  (buf_empty)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader attached to a synchronous-read RAM holding ram[i] = i + 0x10.
module tb_ram_stream_reader;

  localparam int AW = 6;
  localparam int W  = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done_tick;

  logic [W-1:0]  ram [2**AW];
  logic [W-1:0]  exp_q[$];
  int            tests;
  int            fails;
  int            dc;

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .done_tick(done_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = W'(i + 16);
  end

  always @(posedge clk) rd_data <= ram[rd_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    len       = l;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Called at the negedge of cycle 0 (first cycle after the edge that took start).
  // ready_mode 0: m_ready high; 1: 1,0,0,1 then random.
  task automatic run_monitor(input int ready_mode, input int max_cycles, input int restart_at,
                             output int done_count);
    logic [3:0] pat;
    bit stalled;
    int post;
    pat        = 4'b1001;
    stalled    = 1'b0;
    post       = 0;
    done_count = 0;
    for (int c = 0; c < max_cycles; c++) begin
      if (ready_mode == 0) m_ready = 1'b1;
      else if (c < 4) m_ready = pat[c];
      else m_ready = 1'($urandom_range(0, 1));
      start = (c == restart_at);
      if (c == restart_at) begin
        base_addr = AW'(20);
        len       = 7'd5;
      end
      #1;
      if (stalled) check("stall_hold_valid", 32'(m_valid), 32'd1);
      if (m_valid) begin
        if (exp_q.size() == 0) check("word_when_none_expected", 32'(exp_q.size()), 32'd1);
        else check("stream_data", 32'(m_data), 32'(exp_q[0]));
      end
      stalled = m_valid && !m_ready;
      if (m_valid && m_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (done_tick) begin
        done_count++;
        check("done_words_left", 32'(exp_q.size()), 32'd0);
      end
      if (done_count > 0) post++;
      if (post > 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    if (done_count == 0) check("done_timeout", 32'(done_count), 32'd1);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_tick), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    reset = 1'b0;

    // base 5, len 4, ready high: data on cycles 2..5, done cycle 5, busy low cycle 6
    m_ready = 1'b1;
    do_start(6'd5, 7'd4);
    for (int c = 0; c < 8; c++) begin
      #1;
      check("t1_valid", 32'(m_valid), 32'((c >= 2) && (c <= 5)));
      if (c >= 2 && c <= 5) check("t1_data", 32'(m_data), 32'(8'h15 + c - 2));
      check("t1_done", 32'(done_tick), 32'(c == 5));
      check("t1_busy", 32'(busy), 32'(c <= 5));
      @(negedge clk);
    end

    // wrap 63 -> 0
    exp_q.delete();
    exp_q.push_back(8'h4E);
    exp_q.push_back(8'h4F);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    do_start(6'd62, 7'd4);
    run_monitor(0, 40, -1, dc);
    check("t2_done_count", 32'(dc), 32'd1);
    check("t2_rd_addr_end", 32'(rd_addr), 32'd2);

    // len 0: done one cycle after start, nothing read, address left at 2
    m_ready = 1'b1;
    do_start(6'd7, 7'd0);
    #1;
    check("t4_done", 32'(done_tick), 32'd1);
    check("t4_valid", 32'(m_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_rd_addr", 32'(rd_addr), 32'd2);
    @(negedge clk);
    #1;
    check("t4_done_once", 32'(done_tick), 32'd0);
    check("t4_valid_after", 32'(m_valid), 32'd0);
    check("t4_rd_addr_after", 32'(rd_addr), 32'd2);

    // base 0, len 8, ready 1,0,0,1 then random
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(8'h10 + i));
    do_start(6'd0, 7'd8);
    run_monitor(1, 300, -1, dc);
    check("t3_done_count", 32'(dc), 32'd1);

    // full 64-word sweep, second start at cycle 10 ignored
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(W'(8'h10 + i));
    do_start(6'd0, 7'd64);
    run_monitor(0, 120, 10, dc);
    check("t5_done_count", 32'(dc), 32'd1);
    check("t5_busy_end", 32'(busy), 32'd0);
    check("t5_rd_addr_end", 32'(rd_addr), 32'd0);

    // reset mid-burst with ready low, then a fresh one-word burst
    m_ready = 1'b0;
    do_start(6'd0, 7'd16);
    for (int c = 0; c < 6; c++) begin
      #1;
      check("t6_no_done", 32'(done_tick), 32'd0);
      if (c == 5) begin
        check("t6_valid_pre", 32'(m_valid), 32'd1);
        check("t6_data_pre", 32'(m_data), 32'h10);
        reset = 1'b1;
      end
      @(negedge clk);
    end
    #1;
    check("t6_valid_rst", 32'(m_valid), 32'd0);
    check("t6_data_rst", 32'(m_data), 32'd0);
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_done_rst", 32'(done_tick), 32'd0);
    check("t6_rd_addr_rst", 32'(rd_addr), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("t6_idle_valid", 32'(m_valid), 32'd0);
      check("t6_idle_done", 32'(done_tick), 32'd0);
    end
    exp_q.delete();
    exp_q.push_back(8'h13);
    do_start(6'd3, 7'd1);
    run_monitor(0, 30, -1, dc);
    check("t6_done_count", 32'(dc), 32'd1);
    check("t6_rd_addr_end", 32'(rd_addr), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
